ws2801_strip_driver: RTL and testbench

Synthesizable controller that streams a frame of 24-bit pixels from a pixel buffer onto a WS2801 LED strip. It serializes each pixel MSB-first (red[7] first, blue[0] last) on `sdo`/`cko`, then holds `cko` low for the latch gap so the strip loads the frame. It sits between the frame/pixel buffer and the strip connector pins, and it sequences whole-frame refreshes on a start/done handshake.

---
 rtl/ws2801_pkg.sv | 27 ++
 rtl/ws2801_strip_driver_if.sv | 41 ++++
 rtl/ws2801_bit_shifter.sv | 69 ++++++
 rtl/ws2801_strip_driver.sv | 114 +++++++++++
 tb/tb_ws2801_strip_driver.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2801_pkg.sv
// Shared types and constants for the WS2801 strip driver.
package ws2801_pkg;

    // Minimum low time on cko that makes a WS2801 latch its shift register.
    localparam int LATCH_US = 500;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    // Smallest LATCH_CYCLES value that still honours the strip latch time
    // for a given system clock in kHz (rounded up).
    function automatic int min_latch_cycles(input int clk_khz);
        return (LATCH_US * clk_khz + 999) / 1000;
    endfunction

endpackage

// File: rtl/ws2801_strip_driver_if.sv
// Signal bundle between the strip driver, the pixel buffer and the strip pins.
interface ws2801_strip_driver_if
    import ws2801_pkg::*;
#(
    parameter int AW = 6
);

    logic          start;
    logic          busy;
    logic          done;
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    rgb_t          pix_data;
    logic          sdo;
    logic          cko;

    // The driver side.
    modport master (
        input  start,
        input  pix_data,
        output busy,
        output done,
        output pix_rd,
        output pix_addr,
        output sdo,
        output cko
    );

    // The host / buffer / strip side.
    modport slave (
        output start,
        output pix_data,
        input  busy,
        input  done,
        input  pix_rd,
        input  pix_addr,
        input  sdo,
        input  cko
    );

endinterface

// File: rtl/ws2801_bit_shifter.sv
// Serialises one 24-bit pixel MSB-first onto sdo/cko. Each bit is a low
// phase of CLK_DIV cycles (sdo updated at its start) followed by a high
// phase of CLK_DIV cycles. last_bit_done is high during the final cycle of
// bit 0's high phase so the controller can move on at the same edge.
module ws2801_bit_shifter
    import ws2801_pkg::*;
#(
    parameter int CLK_DIV = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  rgb_t pix,
    output logic sdo,
    output logic cko,
    output logic last_bit_done
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [23:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [DW-1:0] div;
    logic          active;
    logic          phase_end;

    // cko itself tells which half of the bit we are in.
    assign phase_end     = active && (div == DW'(CLK_DIV - 1));
    assign last_bit_done = phase_end && cko && (bit_cnt == 5'd0);

    // Shift register, bit counter and half-period divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div     <= '0;
            active  <= 1'b0;
            sdo     <= 1'b0;
            cko     <= 1'b0;
        end else if (load) begin
            shreg   <= pix;
            bit_cnt <= 5'd23;
            div     <= '0;
            active  <= 1'b1;
            sdo     <= pix.red[7];
            cko     <= 1'b0;
        end else if (active) begin
            if (!phase_end) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (!cko) begin
                    cko <= 1'b1;
                end else begin
                    cko <= 1'b0;
                    if (bit_cnt == 5'd0) begin
                        active <= 1'b0;
                        sdo    <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        shreg   <= {shreg[22:0], 1'b0};
                        sdo     <= shreg[22];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ws2801_strip_driver.sv
// Frame sequencer for a WS2801 strip: fetches each pixel from a
// synchronous-read buffer, hands it to the bit shifter, then holds cko low
// for the latch gap and reports completion on done.
module ws2801_strip_driver
    import ws2801_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 25_000,
    parameter int AW           = (LEDS > 1) ? $clog2(LEDS) : 1
)(
    input logic                   clk,
    input logic                   rst,
    ws2801_strip_driver_if.master bus
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] index;
    logic [LW-1:0] latch_cnt;
    logic          busy_q;
    logic          done_q;
    logic          pix_rd_q;
    logic          busy_d;
    logic          done_d;
    logic          pix_rd_d;
    logic          last_pixel;
    logic          latch_end;
    logic          last_bit_done;
    logic          sdo;
    logic          cko;

    assign last_pixel = (index == AW'(LEDS - 1));
    assign latch_end  = (latch_cnt == LW'(LATCH_CYCLES - 1));

    ws2801_bit_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk           (clk),
        .rst           (rst),
        .load          (state == LOAD),
        .pix           (bus.pix_data),
        .sdo           (sdo),
        .cko           (cko),
        .last_bit_done (last_bit_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the next values of the registered handshake outputs.
    always_comb begin
        next_state = state;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pix_rd_d   = 1'b0;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (last_bit_done) next_state = last_pixel ? LATCH : FETCH;
            LATCH: begin
                if (latch_end) begin
                    next_state = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        busy_d   = (next_state != IDLE);
        pix_rd_d = (next_state == FETCH);
    end

    // Registered outputs, pixel index and latch-gap timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pix_rd_q  <= 1'b0;
            index     <= '0;
            latch_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            pix_rd_q <= pix_rd_d;
            if (state == IDLE && bus.start) begin
                index <= '0;
            end else if (state == SHIFT && last_bit_done && !last_pixel) begin
                index <= index + 1'b1;
            end
            if (state == LATCH) begin
                latch_cnt <= latch_cnt + 1'b1;
            end else begin
                latch_cnt <= '0;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pix_rd   = pix_rd_q;
    assign bus.pix_addr = index;
    assign bus.sdo      = sdo;
    assign bus.cko      = cko;

endmodule

// File: tb/tb_ws2801_strip_driver.sv
// Scoreboard bench for ws2801_strip_driver: a 3-pixel instance driving a
// chain of three behavioural WS2801 models and a 1-pixel instance driving one.
// Clock is 12.5 MHz, so the strip latch timeout of 500 us is 6250 cycles.
`timescale 1ns/1ps
module tb_ws2801_strip_driver;
    import ws2801_pkg::*;

    localparam int STRIP_TIMEOUT = 6250;

    typedef struct { int addr; int cyc; } rd_item_t;
    typedef struct { int cyc; int run; } done_item_t;
    typedef struct { logic [23:0] p0; logic [23:0] p1; logic [23:0] p2; int nbits; } lat_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    rd_item_t   rd3_q[$];
    rd_item_t   rd1_q[$];
    done_item_t done3_q[$];
    done_item_t done1_q[$];
    lat_item_t  lat3_q[$];
    lat_item_t  lat1_q[$];

    int   skip3_req = 0;
    int   skip3_done = 0;
    int   run3 = 0, run1 = 0;
    int   nb3 = 0, nb1 = 0;
    int   low3 = 0, low1 = 0;
    int   toggles3 = 0, toggles1 = 0;
    logic pcko3 = 1'b0, psdo3 = 1'b0, pcko1 = 1'b0, psdo1 = 1'b0;
    logic bits3 [72];
    logic bits1 [24];

    logic [23:0] mem3 [4];
    logic [23:0] mem1 [2];

    always #40 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2801_strip_driver_if #(.AW(2)) bus3 ();
    ws2801_strip_driver_if #(.AW(1)) bus1 ();

    ws2801_strip_driver #(.LEDS(3), .CLK_DIV(1), .LATCH_CYCLES(6375), .AW(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    ws2801_strip_driver #(.LEDS(1), .CLK_DIV(1), .LATCH_CYCLES(6375), .AW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Synchronous-read pixel buffers.
    always @(posedge clk) if (bus3.pix_rd) bus3.pix_data <= mem3[bus3.pix_addr];
    always @(posedge clk) if (bus1.pix_rd) bus1.pix_data <= mem1[bus1.pix_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    endtask

    task automatic flagUnexpected(input string name, input int at);
        checks++;
        $display("[TB] FAIL %s: got an event at cycle %0d, expected none", name, at);
    endtask

    // Expected responses of one full frame started in cycle s.
    // Per pixel 2+48*1 = 50 cycles; frame 1+3*50+6375 = 6526, or 1+50+6375 = 6426 for one LED.
    task automatic pushFrame(input bit single, input int s);
        if (single) begin
            rd1_q.push_back('{0, s + 1});
            done1_q.push_back('{s + 6426, 6425});
            lat1_q.push_back('{mem1[0], 24'h0, 24'h0, 24});
        end else begin
            for (int i = 0; i < 3; i++) rd3_q.push_back('{i, s + 1 + 50 * i});
            done3_q.push_back('{s + 6526, 6525});
            lat3_q.push_back('{mem3[0], mem3[1], mem3[2], 72});
        end
    endtask

    // mode 0: start expected to be ignored; 1: full frame; 2: frame cut by reset during pixel 1.
    task automatic applyStimulus(input bit single, input int mode, output int s);
        s = cyc;
        if (single) bus1.start = 1'b1;
        else bus3.start = 1'b1;
        if (mode == 1) pushFrame(single, s);
        if (mode == 2) begin
            rd3_q.push_back('{0, s + 1});
            rd3_q.push_back('{1, s + 51});
            skip3_req++;
        end
        @(negedge clk);
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor and strip-chain model for the three-pixel driver.
    always @(negedge clk) begin : mon3
        rd_item_t    r;
        done_item_t  d;
        lat_item_t   l;
        logic [23:0] got [3];
        if (bus3.pix_rd) begin
            if (rd3_q.size() == 0) flagUnexpected("rd3 read", cyc);
            else begin
                r = rd3_q.pop_front();
                checkOutput("rd3 addr", 32'(bus3.pix_addr), r.addr);
                checkOutput("rd3 cycle", cyc, r.cyc);
            end
        end
        if (bus3.done) begin
            if (done3_q.size() == 0) flagUnexpected("done3", cyc);
            else begin
                d = done3_q.pop_front();
                checkOutput("done3 cycle", cyc, d.cyc);
                checkOutput("busy3 high cycles", run3, d.run);
                checkOutput("busy3 low at done", 32'(bus3.busy), 0);
            end
        end
        if (bus3.busy) run3++;
        else run3 = 0;
        if (bus3.cko && !pcko3) begin
            if (nb3 < 72) bits3[nb3] = bus3.sdo;
            nb3++;
        end
        if (bus3.cko && pcko3 && (bus3.sdo != psdo3)) toggles3++;
        low3 = bus3.cko ? 0 : low3 + 1;
        if (low3 == STRIP_TIMEOUT && nb3 > 0) begin
            if (skip3_req > skip3_done) skip3_done++;
            else if (lat3_q.size() == 0) flagUnexpected("strip3 latch", cyc);
            else begin
                l = lat3_q.pop_front();
                for (int p = 0; p < 3; p++)
                    for (int b = 0; b < 24; b++) got[p][23 - b] = bits3[p * 24 + b];
                checkOutput("strip3 led0", got[0], l.p0);
                checkOutput("strip3 led1", got[1], l.p1);
                checkOutput("strip3 led2", got[2], l.p2);
                checkOutput("strip3 cko rises", nb3, l.nbits);
            end
            nb3 = 0;
        end
        pcko3 = bus3.cko;
        psdo3 = bus3.sdo;
    end

    // Monitor and single-LED strip model for the one-pixel driver.
    always @(negedge clk) begin : mon1
        rd_item_t    r;
        done_item_t  d;
        lat_item_t   l;
        logic [23:0] got;
        if (bus1.pix_rd) begin
            if (rd1_q.size() == 0) flagUnexpected("rd1 read", cyc);
            else begin
                r = rd1_q.pop_front();
                checkOutput("rd1 addr", 32'(bus1.pix_addr), r.addr);
                checkOutput("rd1 cycle", cyc, r.cyc);
            end
        end
        if (bus1.done) begin
            if (done1_q.size() == 0) flagUnexpected("done1", cyc);
            else begin
                d = done1_q.pop_front();
                checkOutput("done1 cycle", cyc, d.cyc);
                checkOutput("busy1 high cycles", run1, d.run);
            end
        end
        if (bus1.busy) run1++;
        else run1 = 0;
        if (bus1.cko && !pcko1) begin
            if (nb1 < 24) bits1[nb1] = bus1.sdo;
            nb1++;
        end
        if (bus1.cko && pcko1 && (bus1.sdo != psdo1)) toggles1++;
        low1 = bus1.cko ? 0 : low1 + 1;
        if (low1 == STRIP_TIMEOUT && nb1 > 0) begin
            if (lat1_q.size() == 0) flagUnexpected("strip1 latch", cyc);
            else begin
                l = lat1_q.pop_front();
                for (int b = 0; b < 24; b++) got[23 - b] = bits1[b];
                checkOutput("strip1 led0", got, l.p0);
                checkOutput("strip1 cko rises", nb1, l.nbits);
            end
            nb1 = 0;
        end
        pcko1 = bus1.cko;
        psdo1 = bus1.sdo;
    end

    initial begin : stim
        int s;
        int t;
        bus3.start = 1'b0;
        bus1.start = 1'b0;
        mem3 = '{24'hFFFFFF, 24'hF0F0F0, 24'hAA5500, 24'h000000};
        mem1 = '{24'h123456, 24'h000000};
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset busy3", 32'(bus3.busy), 0);
        checkOutput("reset done3", 32'(bus3.done), 0);
        checkOutput("reset pix_rd3", 32'(bus3.pix_rd), 0);
        checkOutput("reset pix_addr3", 32'(bus3.pix_addr), 0);
        checkOutput("reset sdo3", 32'(bus3.sdo), 0);
        checkOutput("reset cko3", 32'(bus3.cko), 0);
        checkOutput("reset busy1", 32'(bus1.busy), 0);
        checkOutput("reset pix_rd1", 32'(bus1.pix_rd), 0);
        checkOutput("reset cko1", 32'(bus1.cko), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single frame");
        applyStimulus(1'b0, 1, s);
        waitUntil(s + 6600);

        $display("[TB] start while busy, pixel 0 = AA5500");
        mem3 = '{24'hAA5500, 24'hFFFFFF, 24'hF0F0F0, 24'h000000};
        applyStimulus(1'b0, 1, s);
        waitUntil(s + 100);
        applyStimulus(1'b0, 0, t);
        waitUntil(s + 500);
        applyStimulus(1'b0, 0, t);
        waitUntil(s + 6000);
        applyStimulus(1'b0, 0, t);
        waitUntil(s + 6600);

        $display("[TB] back-to-back frames");
        mem3 = '{24'hFFFFFF, 24'hF0F0F0, 24'hAA5500, 24'h000000};
        s = cyc;
        bus3.start = 1'b1;
        pushFrame(1'b0, s);
        pushFrame(1'b0, s + 6526);
        waitUntil(s + 6546);
        bus3.start = 1'b0;
        waitUntil(s + 6526 + 6600);

        $display("[TB] reset during pixel 1");
        applyStimulus(1'b0, 2, s);
        waitUntil(s + 70);
        rst = 1'b1;
        waitUntil(s + 71);
        checkOutput("abort cko", 32'(bus3.cko), 0);
        checkOutput("abort sdo", 32'(bus3.sdo), 0);
        checkOutput("abort busy", 32'(bus3.busy), 0);
        checkOutput("abort pix_rd", 32'(bus3.pix_rd), 0);
        checkOutput("abort state", 32'(dut3.state), 32'(IDLE));
        rst = 1'b0;
        waitUntil(s + 71 + 6400);
        applyStimulus(1'b0, 1, s);
        waitUntil(s + 6600);

        $display("[TB] single LED");
        applyStimulus(1'b1, 1, s);
        waitUntil(s + 6500);

        checkOutput("rd3 events missing", rd3_q.size(), 0);
        checkOutput("done3 events missing", done3_q.size(), 0);
        checkOutput("strip3 latches missing", lat3_q.size(), 0);
        checkOutput("strip3 partial latch missing", skip3_req - skip3_done, 0);
        checkOutput("rd1 events missing", rd1_q.size(), 0);
        checkOutput("done1 events missing", done1_q.size(), 0);
        checkOutput("strip1 latches missing", lat1_q.size(), 0);
        checkOutput("sdo3 toggles while cko high", toggles3, 0);
        checkOutput("sdo1 toggles while cko high", toggles1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
